// File: rtl/il1_valid_table.sv
// Valid-bit table for the 4-way L1 instruction cache: two registered read ports
// and a two-phase (index, then one-hot way mask) refill write with NMI on bad masks.
module il1_valid_table #(
  parameter int SETS  = 256,
  parameter int IDX_W = 8,
  parameter int WAYS  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] read_set_index,
  input  logic             write_en,
  input  logic [IDX_W-1:0] write_set_index,
  input  logic [WAYS-1:0]  valid_mask,
  output logic [WAYS-1:0]  valid_bits,
  output logic [WAYS-1:0]  refill_valid_bits,
  output logic             nmi
);

  logic [WAYS-1:0]  r_table [SETS];
  logic             r_pending;
  logic [IDX_W-1:0] r_pend_idx;
  logic [WAYS-1:0]  r_valid_bits;
  logic [WAYS-1:0]  r_refill_valid_bits;
  logic             r_nmi;

  logic             w_onehot;
  logic             w_wr_en;
  logic             w_fault;

  // A single refill fills exactly one way; anything else is a protocol fault.
  assign w_onehot = (valid_mask != '0) &&
                    ((valid_mask & (valid_mask - {{(WAYS-1){1'b0}}, 1'b1})) == '0);
  assign w_wr_en  = r_pending && w_onehot;
  assign w_fault  = r_pending && !w_onehot;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SETS; i++) begin
        r_table[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_table[r_pend_idx] <= r_table[r_pend_idx] | valid_mask;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending           <= 1'b0;
      r_pend_idx          <= '0;
      r_valid_bits        <= '0;
      r_refill_valid_bits <= '0;
      r_nmi               <= 1'b0;
    end else begin
      // Reads sample pre-write table contents.
      r_valid_bits        <= r_table[read_set_index];
      r_refill_valid_bits <= r_table[write_set_index];
      r_nmi               <= w_fault;
      if (w_fault) begin
        r_pending <= 1'b0;
      end else begin
        r_pending <= write_en;
        if (write_en) begin
          r_pend_idx <= write_set_index;
        end
      end
    end
  end

  assign valid_bits        = r_valid_bits;
  assign refill_valid_bits = r_refill_valid_bits;
  assign nmi               = r_nmi;

endmodule

// File: tb/tb_il1_valid_table.sv
// Self-checking bench for il1_valid_table: reference model feeds a scoreboard queue,
// plus directed checks of the documented refill scenarios.
module tb_il1_valid_table;

  logic       clk;
  logic       reset;
  logic [7:0] read_set_index;
  logic       write_en;
  logic [7:0] write_set_index;
  logic [3:0] valid_mask;
  logic [3:0] valid_bits;
  logic [3:0] refill_valid_bits;
  logic       nmi;

  typedef struct packed {
    logic [3:0] vb;
    logic [3:0] rvb;
    logic       nmi;
  } exp_t;

  exp_t       sb_q[$];
  logic [3:0] m_tab [256];
  logic       m_pend;
  logic [7:0] m_pidx;
  int         n_checks;
  int         n_errors;

  il1_valid_table dut (
    .clk               (clk),
    .reset             (reset),
    .read_set_index    (read_set_index),
    .write_en          (write_en),
    .write_set_index   (write_set_index),
    .valid_mask        (valid_mask),
    .valid_bits        (valid_bits),
    .refill_valid_bits (refill_valid_bits),
    .nmi               (nmi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) m_tab[i] = 4'b0000;
    m_pend = 1'b0;
    m_pidx = 8'd0;
    sb_q.delete();
  endtask

  // Drive one cycle of stimulus, predict the outputs, then compare after the edge.
  task automatic step(input logic [7:0] rd, input logic we, input logic [7:0] wi,
                      input logic [3:0] m);
    exp_t e;
    exp_t g;
    logic one;
    read_set_index  = rd;
    write_en        = we;
    write_set_index = wi;
    valid_mask      = m;
    one   = ($countones(m) == 1);
    e.vb  = m_tab[rd];
    e.rvb = m_tab[wi];
    e.nmi = m_pend && !one;
    if (m_pend && one) m_tab[m_pidx] = m_tab[m_pidx] | m;
    if (m_pend && !one) begin
      m_pend = 1'b0;
    end else begin
      m_pend = we;
      if (we) m_pidx = wi;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    g = sb_q.pop_front();
    check("sb_vb",  32'(valid_bits),        32'(g.vb));
    check("sb_rvb", 32'(refill_valid_bits), 32'(g.rvb));
    check("sb_nmi", 32'(nmi),               32'(g.nmi));
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    model_clear();
    #1;
    check("rst_vb",  32'(valid_bits),        32'd0);
    check("rst_rvb", 32'(refill_valid_bits), 32'd0);
    check("rst_nmi", 32'(nmi),               32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    read_set_index  = 8'd0;
    write_en        = 1'b0;
    write_set_index = 8'd0;
    valid_mask      = 4'd0;
    reset           = 1'b1;
    #2;
    pulse_reset();

    // 1: request set 0, mask 0100, read back.
    step(8'd0, 1'b1, 8'd0, 4'b0000);
    step(8'd0, 1'b0, 8'd0, 4'b0100);
    step(8'd0, 1'b0, 8'd0, 4'b0000);
    check("t1_vb", 32'(valid_bits), 32'h4);

    // 2: request set 1, mask 0001; set 0 unchanged on the refill port.
    step(8'd1, 1'b1, 8'd1, 4'b0000);
    step(8'd1, 1'b0, 8'd0, 4'b0001);
    step(8'd1, 1'b0, 8'd0, 4'b0000);
    check("t2_vb",  32'(valid_bits),        32'h1);
    check("t2_rvb", 32'(refill_valid_bits), 32'h4);

    // 3: mask without request ignored; OR-write shows up one cycle late.
    step(8'd0, 1'b0, 8'd0, 4'b0001);
    step(8'd0, 1'b1, 8'd0, 4'b0000);
    step(8'd0, 1'b0, 8'd0, 4'b1000);
    check("t3_old", 32'(valid_bits), 32'h4);
    step(8'd0, 1'b0, 8'd0, 4'b0000);
    check("t3_new", 32'(valid_bits), 32'hC);

    // 4: reset cancels a pending request and clears the table.
    step(8'd2, 1'b1, 8'd2, 4'b0000);
    pulse_reset();
    step(8'd1, 1'b0, 8'd2, 4'b0010);
    step(8'd1, 1'b0, 8'd2, 4'b0000);
    check("t4_set1", 32'(valid_bits),        32'h0);
    check("t4_set2", 32'(refill_valid_bits), 32'h0);
    step(8'd2, 1'b0, 8'd0, 4'b0000);
    check("t4_set2r", 32'(valid_bits), 32'h0);

    // 5: multi-bit mask faults and flushes the concurrent request.
    step(8'd0, 1'b1, 8'd3, 4'b0000);
    step(8'd0, 1'b1, 8'd0, 4'b1111);
    check("t5_nmi", 32'(nmi), 32'h1);
    step(8'd3, 1'b0, 8'd0, 4'b0001);
    check("t5_nmi_clr", 32'(nmi),        32'h0);
    check("t5_set3",    32'(valid_bits), 32'h0);
    step(8'd0, 1'b0, 8'd0, 4'b0000);
    check("t5_set0", 32'(valid_bits), 32'h0);

    // 6: zero mask faults too.
    step(8'd0, 1'b1, 8'd5, 4'b0000);
    step(8'd0, 1'b0, 8'd0, 4'b0000);
    check("t6_nmi", 32'(nmi), 32'h1);
    step(8'd5, 1'b0, 8'd0, 4'b0000);
    check("t6_set5", 32'(valid_bits), 32'h0);
    check("t6_nmi_clr", 32'(nmi), 32'h0);

    // Back-to-back: new request issued alongside the previous write's mask.
    step(8'd0, 1'b1, 8'd7, 4'b0000);
    step(8'd0, 1'b1, 8'd8, 4'b0010);
    step(8'd0, 1'b0, 8'd0, 4'b0100);
    step(8'd7, 1'b0, 8'd8, 4'b0000);
    check("b2b_set7", 32'(valid_bits),        32'h2);
    check("b2b_set8", 32'(refill_valid_bits), 32'h4);

    // Highest index.
    step(8'd0, 1'b1, 8'd255, 4'b0000);
    step(8'd0, 1'b0, 8'd0, 4'b1000);
    step(8'd255, 1'b0, 8'd255, 4'b0000);
    check("top_vb",  32'(valid_bits),        32'h8);
    check("top_rvb", 32'(refill_valid_bits), 32'h8);

    // Random traffic over a small set range, checked by the scoreboard.
    for (int i = 0; i < 300; i++) begin
      step(8'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
